// File: rtl/mem_stage_access_if.sv
// Data-cache request/response bus used by the MEM stage.
//   dmem_address : word-aligned byte address
//   dmem_read    : read request, held until dmem_resp
//   dmem_write   : write request, held until dmem_resp
//   dmem_mbe     : write byte enables
//   dmem_wdata   : lane-placed store data
//   dmem_resp    : cache response, completes the outstanding request
//   dmem_rdata   : cache read word, valid with dmem_resp
// master = MEM stage (requester), slave = data cache.
interface mem_stage_access_if;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_wdata;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_mbe, dmem_wdata,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_mbe, dmem_wdata,
    output dmem_resp, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_access.sv
// MEM-stage load/store access unit.
// Turns a valid load or store from the decoded control word into a single
// data-cache transaction, stalls the pipeline while it is outstanding, and
// returns the aligned, sign/zero-extended load result for writeback.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   valid_i       : MEM control word valid
//   mem_read_i    : load request
//   mem_write_i   : store request
//   funct3_i      : width/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   addr_i        : byte address from the ALU
//   store_data_i  : rs2 value for stores
//   advance_i     : MEM/WB register loads this cycle
//   dmem          : data-cache bus (master side)
//   load_data_o   : extended load result
//   busy_o        : MEM stall request
//   done_o        : access complete, result valid
//   misalign_o    : misaligned access detected, request suppressed
module mem_stage_access (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic                      mem_read_i,
  input  logic                      mem_write_i,
  input  logic [2:0]                funct3_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               store_data_i,
  input  logic                      advance_i,
  mem_stage_access_if.master        dmem,
  output logic [31:0]               load_data_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      misalign_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;

  logic        op_write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mbe_q;
  logic        rd_q;
  logic        wr_q;
  logic [31:0] load_q;
  logic        done_q;

  logic        req;
  logic        is_write;
  logic        misaligned;
  logic [3:0]  mbe_n;
  logic [31:0] wdata_n;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign req = valid_i & (mem_read_i | mem_write_i);
  // A control word asserting both ops is treated as a load.
  assign is_write = mem_write_i & ~mem_read_i;

  // funct3[1:0] encodes width: 00 byte, 01 half, 10/11 word (undefined
  // encodings fall into the word case everywhere, matching lw handling).
  always_comb begin
    misaligned = 1'b0;
    case (funct3_i[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_i[0];
      default: misaligned = |addr_i[1:0];
    endcase
  end

  // Store lane placement: replicate the operand so any lane selected by the
  // byte mask already carries the right bits.
  always_comb begin
    mbe_n   = 4'b1111;
    wdata_n = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        mbe_n   = 4'b0001 << addr_i[1:0];
        wdata_n = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        mbe_n   = 4'b0011 << addr_i[1:0];
        wdata_n = {2{store_data_i[15:0]}};
      end
      default: begin
        mbe_n   = 4'b1111;
        wdata_n = store_data_i;
      end
    endcase
  end

  // Load extraction uses the latched address so the result lines up with the
  // request that was issued, not whatever sits on addr_i at response time.
  always_comb begin
    byte_sel = dmem.dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = dmem.dmem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_write_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mbe_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      load_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !misaligned) begin
            op_write_q <= is_write;
            funct3_q   <= funct3_i;
            addr_q     <= addr_i;
            wdata_q    <= is_write ? wdata_n : '0;
            mbe_q      <= is_write ? mbe_n : '0;
            rd_q       <= ~is_write;
            wr_q       <= is_write;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (dmem.dmem_resp) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            load_q <= op_write_q ? '0 : load_ext;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // Upstream is frozen while we wait here, so nothing is re-issued.
          if (advance_i) begin
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          rd_q   <= 1'b0;
          wr_q   <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign dmem.dmem_address = {addr_q[31:2], 2'b00};
  assign dmem.dmem_read    = rd_q;
  assign dmem.dmem_write   = wr_q;
  assign dmem.dmem_mbe     = mbe_q;
  assign dmem.dmem_wdata   = wdata_q;

  assign load_data_o = load_q;
  assign done_o      = done_q;

  // busy/misalign react to the incoming word in IDLE so the stall takes
  // effect in the same cycle the request appears.
  assign busy_o     = ~rst & ((state == ACCESS) |
                              ((state == IDLE) & req & ~misaligned));
  assign misalign_o = ~rst & (state == IDLE) & req & misaligned;

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- MEM-stage consumer of the decoded control word's MEM field (mem_read, mem_write, funct3) plus the EX-stage ALU address and rs2 data.
- Turns each valid load or store into one data-cache request with a request/response handshake.
- Stalls the pipeline until the data cache responds.
- Returns load data aligned and sign- or zero-extended, ready for the WB regfile mux.

Parameters:
None. Widths are fixed by RV32I: 32-bit address and data, 4-bit byte mask.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  MEM control word valid
mem_read_i  in  1  control word requests a load
mem_write_i  in  1  control word requests a store
funct3_i  in  3  load/store width and sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
addr_i  in  32  byte address from ALU
store_data_i  in  32  rs2 value for stores
advance_i  in  1  MEM/WB pipeline register loads this cycle
dmem_resp  in  1  data cache response
dmem_rdata  in  32  data cache read word
dmem_address  out  32  word-aligned address, {addr[31:2],2'b00}
dmem_read  out  1  read request
dmem_write  out  1  write request
dmem_mbe  out  4  write byte enables
dmem_wdata  out  32  lane-shifted store data
load_data_o  out  32  extended load result
busy_o  out  1  MEM stall request
done_o  out  1  access complete, result valid
misalign_o  out  1  misaligned access, suppressed

Behaviour:
- FSM has three states: IDLE, ACCESS, DONE. Reset enters IDLE.
- Reset values: all outputs 0, captured op/address/data 0.
- IDLE, valid request present (valid_i & (mem_read_i | mem_write_i)), aligned:
  - busy_o=1 combinationally.
  - Latch op, funct3, addr, and shifted store data/mbe.
  - Next state ACCESS.
- IDLE, request misaligned:
  - Misaligned means w with addr[1:0]!=0, or h/hu with addr[0]!=0.
  - misalign_o=1 combinationally, busy_o=0, no request issued, state stays IDLE.
- ACCESS:
  - dmem_read or dmem_write=1, chosen by the latched op. Never both.
  - dmem_address, dmem_mbe and dmem_wdata are held stable.
  - busy_o=1.
  - On dmem_resp=1: capture load result, go to DONE. Requests drop the next cycle.
- DONE:
  - done_o=1, busy_o=0, load_data_o holds the captured value.
  - If advance_i=1, go to IDLE. Otherwise stay; inputs are frozen upstream, so no re-issue.
- Latency: request seen in cycle 0, dmem_read/write high from cycle 1. If resp arrives in cycle k, done_o is high in cycle k+1. Minimum 2 cycles.
- Store lane placement:
  - sb: mbe=4'b0001<<addr[1:0], wdata = byte replicated ×4.
  - sh: mbe=4'b0011<<addr[1:0], wdata = half replicated ×2.
  - sw: mbe=4'b1111, wdata = store_data.
  - Loads drive mbe=0.
- Load extract, using latched addr[1:0]:
  - lb/lbu: byte rdata[8*a+:8].
  - lh/lhu: half rdata[16*a[1]+:16].
  - lw: full word.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Undefined funct3 (011, 110, 111): treat as lw.
- Boundary cases:
  - dmem_resp in IDLE or DONE: ignored.
  - valid_i low or no mem op: pass-through, busy_o=0, done_o=0.
  - rst in any state, including mid-ACCESS: IDLE next cycle, requests deasserted, any later resp ignored.
  - Store completion leaves load_data_o=0.

Test Plan:
- lw addr=0x100, dmem_rdata=0xDEADBEEF, resp in 3rd ACCESS cycle → dmem_read high 3 cycles, dmem_address=0x100, load_data_o=0xDEADBEEF, done_o one cycle, busy_o high 4 cycles.
- lb addr=0x203, rdata=0x80FF_0000 → 0xFFFFFF80. lbu same → 0x00000080. lhu addr=0x202 → 0x000080FF.
- sb addr=0x301, store_data=0x000000AB → dmem_write=1, mbe=4'b0010, wdata=0xABABABAB, address=0x300. sh addr=0x302 → mbe=4'b1100.
- lw addr=0x102 → misalign_o=1, busy_o=0, no dmem_read ever asserted.
- Load completes with advance_i=0 for 3 cycles → stays in DONE, no second request; advance_i=1 → IDLE.
- rst asserted mid-ACCESS, then dmem_resp pulse → dmem_read low after the reset edge, done_o never asserted.
